// File: rtl/beta_pkg.sv
// Shared types for the beta memory arbiter: FSM state encoding, owner tag and
// the arbitration helper used by the grant logic.
package beta_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_WAIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ARB_IDLE,
        REQ  = ARB_REQ,
        WAIT = ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    // On a tie the LSU wins unless the caller asks to favour fetch.
    function automatic arb_owner_t pick_winner(input logic if_req,
                                               input logic ls_req,
                                               input logic prefer_if);
        if (ls_req && !(if_req && prefer_if)) begin
            return OWN_LS;
        end
        return OWN_IF;
    endfunction

endpackage

// File: rtl/beta_arb_timeout.sv
// Response wait counter: cleared on start, counts while enabled, and flags
// expire in the cycle the wait reaches TimeoutCycles (0 disables it).
module beta_arb_timeout #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic start,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth:0] Limit = (CntWidth + 1)'(TimeoutCycles);

    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    // The current wait cycle is cnt_q+1, so expiry fires on the TimeoutCycles-th cycle.
    assign expire = (TimeoutCycles != 0) && enable &&
                    (({1'b0, cnt_q} + (CntWidth + 1)'(1)) == Limit);

endmodule

// File: rtl/beta_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction
// at a time. Define BETA_ARB_RR_EN for round-robin; default is LSU-priority.
//
// state | meaning
// IDLE  | sample requests, latch winner and owner tag
// REQ   | drive memory request from the winner's live inputs
// WAIT  | wait for memory response or timeout
module beta_mem_arbiter
    import beta_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,

    input  logic                   arb_if_req_i,
    input  logic [DataWidth-1:0]   arb_if_addr_i,
    output logic                   arb_if_ready_o,
    output logic                   arb_if_valid_o,
    output logic [DataWidth-1:0]   arb_if_rdata_o,
    input  logic                   arb_if_flush_i,

    input  logic                   arb_ls_req_i,
    input  logic                   arb_ls_we_i,
    input  logic [DataWidth/8-1:0] arb_ls_be_i,
    input  logic [DataWidth-1:0]   arb_ls_addr_i,
    input  logic [DataWidth-1:0]   arb_ls_wdata_i,
    output logic                   arb_ls_ready_o,
    output logic                   arb_ls_valid_o,
    output logic [DataWidth-1:0]   arb_ls_rdata_o,

    output logic                   arb_mem_req_o,
    output logic                   arb_mem_we_o,
    output logic [DataWidth/8-1:0] arb_mem_be_o,
    output logic [DataWidth-1:0]   arb_mem_addr_o,
    output logic [DataWidth-1:0]   arb_mem_wdata_o,
    input  logic                   arb_mem_ready_i,
    input  logic                   arb_mem_valid_i,
    input  logic [DataWidth-1:0]   arb_mem_rdata_i,

    output logic                   arb_timeout_o,
    output logic                   arb_busy_o
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, winner;
    logic       drop_q, drop_d;
    logic       any_req, in_req, in_wait, accept, resp, expire, flush_hit, owner_if;

    assign any_req  = arb_if_req_i | arb_ls_req_i;
    assign in_req   = (state_q == REQ);
    assign in_wait  = (state_q == WAIT);
    assign owner_if = (owner_q == OWN_IF);
    assign accept   = in_req & arb_mem_ready_i;
    assign resp     = in_wait & arb_mem_valid_i;
    assign flush_hit = arb_if_flush_i & owner_if & (in_req | in_wait);

`ifdef BETA_ARB_RR_EN
    logic prefer_if_q;

    // Favour whichever requester was not granted last time.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prefer_if_q <= 1'b0;
        end else if ((state_q == IDLE) && any_req) begin
            prefer_if_q <= (winner == OWN_LS);
        end
    end

    assign winner = pick_winner(arb_if_req_i, arb_ls_req_i, prefer_if_q);
`else
    assign winner = pick_winner(arb_if_req_i, arb_ls_req_i, 1'b0);
`endif

    beta_arb_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .start  (accept),
        .enable (in_wait),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = REQ;
            REQ:     if (arb_mem_ready_i) state_d = WAIT;
            WAIT:    if (arb_mem_valid_i || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (flush_hit) drop_d = 1'b1;
        if (state_d == IDLE) drop_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if ((state_q == IDLE) && any_req) begin
                owner_q <= winner;
            end
        end
    end

    always_comb begin
        arb_mem_req_o   = 1'b0;
        arb_mem_we_o    = 1'b0;
        arb_mem_be_o    = '0;
        arb_mem_addr_o  = '0;
        arb_mem_wdata_o = '0;
        if (in_req) begin
            arb_mem_req_o = 1'b1;
            if (owner_if) begin
                arb_mem_be_o   = '1;
                arb_mem_addr_o = arb_if_addr_i;
            end else begin
                arb_mem_we_o    = arb_ls_we_i;
                arb_mem_be_o    = arb_ls_be_i;
                arb_mem_addr_o  = arb_ls_addr_i;
                arb_mem_wdata_o = arb_ls_wdata_i;
            end
        end
    end

    assign arb_if_ready_o = accept & owner_if;
    assign arb_ls_ready_o = accept & ~owner_if;

    // A flush in the response cycle itself also kills the fetch response.
    assign arb_if_valid_o = resp & owner_if & ~drop_q & ~arb_if_flush_i;
    assign arb_ls_valid_o = resp & ~owner_if;
    assign arb_if_rdata_o = arb_if_valid_o ? arb_mem_rdata_i : '0;
    assign arb_ls_rdata_o = arb_ls_valid_o ? arb_mem_rdata_i : '0;

    assign arb_timeout_o  = in_wait & expire & ~arb_mem_valid_i;
    assign arb_busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Self-checking bench for beta_mem_arbiter (TimeoutCycles=4): vector table of
// single transactions, hand sequences for arbitration, flush, timeout and reset.
module tb_beta_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        if_req = 0, if_flush = 0, ls_req = 0, ls_we = 0;
    logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
    logic [3:0]  ls_be = 0;
    logic        mem_ready = 0, mem_valid = 0;
    logic        if_ready, if_valid, ls_ready, ls_valid;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, timeout, busy;
    logic [3:0]  mem_be;

    always #5 clk_i = ~clk_i;

    beta_mem_arbiter #(.DataWidth(32), .TimeoutCycles(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .arb_if_req_i(if_req), .arb_if_addr_i(if_addr), .arb_if_ready_o(if_ready),
        .arb_if_valid_o(if_valid), .arb_if_rdata_o(if_rdata), .arb_if_flush_i(if_flush),
        .arb_ls_req_i(ls_req), .arb_ls_we_i(ls_we), .arb_ls_be_i(ls_be),
        .arb_ls_addr_i(ls_addr), .arb_ls_wdata_i(ls_wdata), .arb_ls_ready_o(ls_ready),
        .arb_ls_valid_o(ls_valid), .arb_ls_rdata_o(ls_rdata),
        .arb_mem_req_o(mem_req), .arb_mem_we_o(mem_we), .arb_mem_be_o(mem_be),
        .arb_mem_addr_o(mem_addr), .arb_mem_wdata_o(mem_wdata), .arb_mem_ready_i(mem_ready),
        .arb_mem_valid_i(mem_valid), .arb_mem_rdata_i(mem_rdata),
        .arb_timeout_o(timeout), .arb_busy_o(busy)
    );

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stall;
    } vec_t;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
    } resp_t;

    vec_t  vecs[5];
    resp_t sb[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Every response the DUT presents must match the next scoreboard entry.
    always @(negedge clk_i) begin
        if (rstn_i && (if_valid || ls_valid)) begin
            if (if_valid && ls_valid) begin
                check("both_valid", 32'({if_valid, ls_valid}), 32'b01);
            end else if (sb.size() == 0) begin
                check("spurious_valid", 32'({if_valid, ls_valid}), 32'b00);
            end else begin
                resp_t e;
                e = sb.pop_front();
                check("resp_owner", 32'(ls_valid), 32'(e.is_ls));
                check("resp_data", ls_valid ? ls_rdata : if_rdata, e.data);
            end
        end
    end

    task automatic idle_inputs();
        if_req = 0; ls_req = 0; if_flush = 0; mem_ready = 0; mem_valid = 0;
    endtask

    task automatic do_txn(input vec_t v);
        if_req   = !v.is_ls;
        ls_req   = v.is_ls;
        if_addr  = v.is_ls ? 32'hBAD0_0000 : v.addr;
        ls_addr  = v.is_ls ? v.addr : 32'hBAD1_0000;
        ls_we    = v.is_ls ? v.we : 1'b1;
        ls_be    = v.is_ls ? v.be : 4'h5;
        ls_wdata = v.is_ls ? v.wdata : 32'h5555_AAAA;
        mem_ready = 0; mem_valid = 0;
        @(negedge clk_i);
        check("txn_idle_busy", 32'(busy), 32'd0);
        cyc();
        for (int k = 0; k < v.stall; k++) begin
            @(negedge clk_i);
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_addr", mem_addr, v.addr);
            check("stall_ready", 32'({if_ready, ls_ready}), 32'd0);
            cyc();
        end
        mem_ready = 1;
        @(negedge clk_i);
        check("acc_req", 32'(mem_req), 32'd1);
        check("acc_we", 32'(mem_we), 32'(v.we));
        check("acc_be", 32'(mem_be), 32'(v.be));
        check("acc_addr", mem_addr, v.addr);
        check("acc_wdata", mem_wdata, v.wdata);
        check("acc_if_ready", 32'(if_ready), 32'(!v.is_ls));
        check("acc_ls_ready", 32'(ls_ready), 32'(v.is_ls));
        sb.push_back('{v.is_ls, v.rdata});
        cyc();
        if_req = 0; ls_req = 0; mem_ready = 0; mem_valid = 1; mem_rdata = v.rdata;
        @(negedge clk_i);
        check("resp_busy", 32'(busy), 32'd1);
        cyc();
        mem_valid = 0;
    endtask

    // Drives one request through acceptance; returns in the first WAIT cycle.
    task automatic accept_phase(input logic is_ls, input logic [31:0] addr);
        if_req = !is_ls; ls_req = is_ls; if_addr = addr; ls_addr = addr;
        ls_we = 0; ls_be = 4'hF; mem_ready = 0; mem_valid = 0;
        @(negedge clk_i);
        cyc();
        mem_ready = 1;
        @(negedge clk_i);
        check("accept_ready", 32'(is_ls ? ls_ready : if_ready), 32'd1);
        cyc();
        mem_ready = 0; if_req = 0; ls_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ls;
        vec_t lsr;
        vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0000_0013, 0};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 2};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0204, 32'h1234_5678, 32'h0000_0000, 0};
        vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h0000_0033, 10};
        vecs[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_03FC, 32'hA5A5_0F0F, 32'h0000_0001, 1};
        lsr     = '{1'b1, 1'b0, 4'hF, 32'h0000_0240, 32'h0, 32'h1111_2222, 0};

        // Reset state with requests pending
        if_req = 1; ls_req = 1;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ready", 32'({if_ready, ls_ready}), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        idle_inputs();
        cyc();
        rstn_i = 1;
        cyc();

        // Both requesting for four grants, LSU writing to 0x200
        if_req = 1; ls_req = 1; ls_we = 1; ls_be = 4'hF;
        ls_addr = 32'h200; ls_wdata = 32'hCAFE_0000; if_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
`ifdef BETA_ARB_RR_EN
            exp_ls = (i % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            mem_ready = 0; mem_valid = 0;
            @(negedge clk_i);
            check("arb_idle", 32'(busy), 32'd0);
            cyc();
            mem_ready = 1;
            @(negedge clk_i);
            check("arb_grant_ls", 32'(ls_ready), 32'(exp_ls));
            check("arb_grant_if", 32'(if_ready), 32'(!exp_ls));
            check("arb_addr", mem_addr, exp_ls ? 32'h200 : 32'h300);
            check("arb_we", 32'(mem_we), 32'(exp_ls));
            sb.push_back('{exp_ls, 32'hA000 + 32'(i)});
            cyc();
            mem_ready = 0; mem_valid = 1; mem_rdata = 32'hA000 + 32'(i);
            @(negedge clk_i);
            cyc();
            mem_valid = 0;
        end
        idle_inputs();
        cyc();

        for (int i = 0; i < 5; i++) do_txn(vecs[i]);

        // Flush during WAIT drops the fetch response
        accept_phase(1'b0, 32'h108);
        if_flush = 1;
        @(negedge clk_i);
        check("flush_busy", 32'(busy), 32'd1);
        cyc();
        if_flush = 0; mem_valid = 1; mem_rdata = 32'h77;
        @(negedge clk_i);
        check("flush_no_valid", 32'(if_valid), 32'd0);
        cyc();
        mem_valid = 0;
        @(negedge clk_i);
        check("flush_idle", 32'(busy), 32'd0);
        cyc();

        // Flush coincident with the response
        accept_phase(1'b0, 32'h10C);
        if_flush = 1; mem_valid = 1; mem_rdata = 32'h88;
        @(negedge clk_i);
        check("flush_same_valid", 32'(if_valid), 32'd0);
        check("flush_same_rdata", if_rdata, 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk_i);
        check("flush_same_idle", 32'(busy), 32'd0);
        cyc();

        do_txn(lsr);

        // Flush has no effect on an LSU transaction
        accept_phase(1'b1, 32'h250);
        if_flush = 1; mem_valid = 1; mem_rdata = 32'h3333;
        sb.push_back('{1'b1, 32'h3333});
        @(negedge clk_i);
        check("flush_ls_valid", 32'(ls_valid), 32'd1);
        cyc();
        idle_inputs();
        cyc();

        // Timeout four cycles after acceptance
        accept_phase(1'b0, 32'h400);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_i);
            check("to_early", 32'(timeout), 32'd0);
            check("to_busy", 32'(busy), 32'd1);
            cyc();
        end
        @(negedge clk_i);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_no_valid", 32'(if_valid), 32'd0);
        cyc();
        @(negedge clk_i);
        check("to_idle", 32'(busy), 32'd0);
        check("to_single", 32'(timeout), 32'd0);
        cyc();

        // Response on the expiry cycle wins over the timeout
        accept_phase(1'b0, 32'h404);
        for (int k = 1; k < 4; k++) cyc();
        mem_valid = 1; mem_rdata = 32'h99;
        sb.push_back('{1'b0, 32'h99});
        @(negedge clk_i);
        check("to_valid_wins", 32'(timeout), 32'd0);
        cyc();
        @(negedge clk_i);
        check("to_valid_idle", 32'(busy), 32'd0);
        cyc();
        mem_valid = 0;

        // Reset during WAIT, then a late response
        accept_phase(1'b1, 32'h500);
        rstn_i = 0;
        #1;
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_outs", 32'({mem_req, ls_ready, ls_valid, timeout}), 32'd0);
        cyc();
        rstn_i = 1;
        mem_valid = 1; mem_rdata = 32'hBAD;
        @(negedge clk_i);
        check("late_valid", 32'(ls_valid), 32'd0);
        check("late_busy", 32'(busy), 32'd0);
        cyc();
        idle_inputs();
        cyc();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
